// File: rtl/register_file_sb.sv
// Integer register file x0..x31 with two combinational read ports, same-cycle
// writeback bypass, and a single-bit pending-write scoreboard for hazard detection.
module register_file_sb #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_wr_en,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [WIDTH-1:0] rs1_data,
  output logic [WIDTH-1:0] rs2_data,
  input  logic             iss_valid,
  input  logic             iss_wr_en,
  input  logic [4:0]       iss_rd,
  output logic             rs1_busy,
  output logic             rs2_busy
);

  // x0 has no storage; it reads as zero and ignores writes.
  logic [WIDTH-1:0]    regs_q [1:NUM_REGS-1];
  logic [WIDTH-1:0]    regs_d [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  logic wb_hit;
  logic iss_hit;
  assign wb_hit  = wb_wr_en && (wb_rd != 5'd0);
  assign iss_hit = iss_valid && iss_wr_en && (iss_rd != 5'd0);

  assign busy_d[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      assign regs_d[gi] = (wb_hit && (wb_rd == 5'(gi))) ? wb_data : regs_q[gi];
      // Set wins over clear: the newly issued write is younger than the one retiring.
      assign busy_d[gi] = (iss_hit && (iss_rd == 5'(gi))) ||
                          (busy_q[gi] && !(wb_hit && (wb_rd == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  logic [WIDTH-1:0] rd1_val;
  logic [WIDTH-1:0] rd2_val;
  logic             byp1;
  logic             byp2;

  always_comb begin
    rd1_val = '0;
    rd2_val = '0;
    byp1    = wb_wr_en && (wb_rd == rs1_addr);
    byp2    = wb_wr_en && (wb_rd == rs2_addr);
    if (rs1_addr != 5'd0) begin
      rd1_val = byp1 ? wb_data : regs_q[rs1_addr];
    end
    if (rs2_addr != 5'd0) begin
      rd2_val = byp2 ? wb_data : regs_q[rs2_addr];
    end
  end

  // Outputs are forced to zero while reset is held, even if the WB bus is active.
  always_comb begin
    rs1_data = rst ? '0 : rd1_val;
    rs2_data = rst ? '0 : rd2_val;
    rs1_busy = !rst && busy_q[rs1_addr] && !byp1;
    rs2_busy = !rst && busy_q[rs2_addr] && !byp2;
  end

endmodule
